// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types, funct3 constants and decode helper for the
//               shifter issue stage. Honors macro SHIFT_ISSUE_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    localparam logic [2:0] C_FUNCT3_SLL = 3'b001;
    localparam logic [2:0] C_FUNCT3_SR  = 3'b101;

    typedef struct packed {
        shift_op_e   op;
        logic [4:0]  shamt;
        logic [31:0] operand;
`ifdef SHIFT_ISSUE_ERR_EN
        logic        err;
`endif
    } shift_req_t;

    // Anything not recognised decodes as SRL so the shifter never sees S=01.
    function automatic shift_req_t decode_req(
        input logic [2:0]  funct3,
        input logic        funct7b5,
        input logic [4:0]  shamt,
        input logic [31:0] operand
    );
        shift_req_t req;
        req         = '0;
        req.op      = OP_SRL;
        req.shamt   = shamt;
        req.operand = operand;
        if (funct3 == C_FUNCT3_SLL && !funct7b5) begin
            req.op = OP_SLL;
        end else if (funct3 == C_FUNCT3_SR) begin
            req.op = funct7b5 ? OP_SRA : OP_SRL;
        end
`ifdef SHIFT_ISSUE_ERR_EN
        else begin
            req.err = 1'b1;
        end
`endif
        return req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_op_fifo.sv
// ============================================================================
// Module      : shift_op_fifo
// Description : Two-entry circular queue of decoded shift requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_op_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  shift_req_t push_data,
    input  logic       pop,
    output shift_req_t pop_data,
    output logic       full,
    output logic       empty
);

    // Storage is not reset: contents are don't-care while the count is zero.
    shift_req_t r_mem [DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == 2'd2);
    assign empty    = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/shift_issue_stage.sv
// ============================================================================
// Module      : shift_issue_stage
// Description : Decodes shift ops, queues them, drives the external shifter
//               from the queue head and registers its result.
//               Optional macro: SHIFT_ISSUE_ERR_EN (illegal-op error flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic        in_imm_sel,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_shamt_imm,
    output logic [1:0]  sh_S,
    output logic [4:0]  sh_shift,
    output logic [31:0] sh_B,
    input  logic [31:0] sh_H,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef SHIFT_ISSUE_ERR_EN
    ,
    output logic        out_err
`endif
);

    shift_req_t  w_enq_req;
    shift_req_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_head_err;
    logic [4:0]  w_shamt;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_err;

    // Only the low five rs2 bits form a shift amount.
    logic        w_unused_rs2_hi;
    assign w_unused_rs2_hi = &{1'b0, in_rs2[31:5]};

    assign w_shamt   = in_imm_sel ? in_shamt_imm : in_rs2[4:0];
    assign w_enq_req = decode_req(in_funct3, in_funct7b5, w_shamt, in_rs1);

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && (!r_out_valid || out_ready);

    shift_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_enq_req),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

`ifdef SHIFT_ISSUE_ERR_EN
    assign w_head_err = w_head.err;
`else
    assign w_head_err = 1'b0;
`endif

    // Idle and errored heads present SRL by 0 of zero: a harmless legal select.
    always_comb begin
        sh_S     = OP_SRL;
        sh_shift = 5'd0;
        sh_B     = 32'd0;
        if (!w_empty && !w_head_err) begin
            sh_S     = w_head.op;
            sh_shift = w_head.shamt;
            sh_B     = w_head.operand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_err   <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head_err ? 32'd0 : sh_H;
            r_out_err   <= w_head_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef SHIFT_ISSUE_ERR_EN
    assign out_err = r_out_err;
`else
    logic w_unused_err;
    assign w_unused_err = r_out_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
// ============================================================================
// Module      : tb_shift_issue_stage
// Description : Directed self-checking bench for shift_issue_stage, with a
//               behavioural barrel shifter. Honors macro SHIFT_ISSUE_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_issue_stage;

`ifdef SHIFT_ISSUE_ERR_EN
    localparam bit C_ERR_EN = 1'b1;
`else
    localparam bit C_ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        in_imm_sel;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_shamt_imm;
    logic [1:0]  sh_S;
    logic [4:0]  sh_shift;
    logic [31:0] sh_B;
    logic [31:0] sh_H;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    shift_issue_stage #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .in_imm_sel   (in_imm_sel),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_shamt_imm (in_shamt_imm),
        .sh_S         (sh_S),
        .sh_shift     (sh_shift),
        .sh_B         (sh_B),
        .sh_H         (sh_H),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef SHIFT_ISSUE_ERR_EN
        ,
        .out_err      (out_err)
`endif
    );

`ifndef SHIFT_ISSUE_ERR_EN
    assign out_err = 1'b0;
`endif

    // External shifter model; S=01 yields a poison value.
    always_comb begin
        case (sh_S)
            2'b00:   sh_H = sh_B << sh_shift;
            2'b10:   sh_H = sh_B >> sh_shift;
            2'b11:   sh_H = $unsigned($signed(sh_B) >>> sh_shift);
            default: sh_H = 32'hDEAD_BEEF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (sh_S == 2'b01) begin
                errors++;
                $display("FAIL sh_S_never_01 actual=%b required=not 01", sh_S);
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic b5, input logic isel,
                            input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm);
        in_valid     = 1'b1;
        in_funct3    = f3;
        in_funct7b5  = b5;
        in_imm_sel   = isel;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_shamt_imm = imm;
    endtask

    typedef struct {
        logic [2:0]  funct3;
        logic        b5;
        logic        imm_sel;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  imm;
        logic [1:0]  exp_s;
        logic [4:0]  exp_shift;
        logic [31:0] exp_b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0004, 5'd0,
                    2'b00, 5'd4, 32'h0000_0001, 32'h0000_0010, 1'b0};
        vecs[1] = '{3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 5'd31,
                    2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 5'd31,
                    2'b10, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0};
        vecs[3] = '{3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FF23, 5'd0,
                    2'b00, 5'd3, 32'h0000_0001, 32'h0000_0008, 1'b0};
        vecs[4] = '{3'b001, 1'b0, 1'b1, 32'hA5A5_0F0F, 32'h0000_0007, 5'd8,
                    2'b00, 5'd8, 32'hA5A5_0F0F, 32'hA50F_0F00, 1'b0};
        vecs[5] = '{3'b101, 1'b1, 1'b0, 32'h7000_0000, 32'h0000_0004, 5'd0,
                    2'b11, 5'd4, 32'h7000_0000, 32'h0700_0000, 1'b0};
        vecs[6] = '{3'b101, 1'b0, 1'b0, 32'hF000_000F, 32'h0000_0000, 5'd9,
                    2'b10, 5'd0, 32'hF000_000F, 32'hF000_000F, 1'b0};
        vecs[7] = '{3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 5'd4,
                    2'b10, C_ERR_EN ? 5'd0 : 5'd4, C_ERR_EN ? 32'd0 : 32'h1234_5678,
                    C_ERR_EN ? 32'd0 : 32'h0123_4567, C_ERR_EN};
        vecs[8] = '{3'b001, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0000, 5'd1,
                    2'b10, C_ERR_EN ? 5'd0 : 5'd1, C_ERR_EN ? 32'd0 : 32'h0000_0080,
                    C_ERR_EN ? 32'd0 : 32'h0000_0040, C_ERR_EN};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_funct3    = 3'b000;
        in_funct7b5  = 1'b0;
        in_imm_sel   = 1'b0;
        in_rs1       = 32'd0;
        in_rs2       = 32'd0;
        in_shamt_imm = 5'd0;
        out_ready    = 1'b1;
        tick();
        tick();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_sh_S", {30'd0, sh_S}, 32'd2);
        check("idle_sh_shift", {27'd0, sh_shift}, 32'd0);
        check("idle_sh_B", sh_B, 32'd0);
        check("reset_out_err", {31'd0, out_err}, 32'd0);
        rst_n = 1'b1;

        // Single ops: enqueue, inspect head controls, then the result.
        for (int i = 0; i < 9; i++) begin
            drive_op(vecs[i].funct3, vecs[i].b5, vecs[i].imm_sel,
                     vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_sh_S", i), {30'd0, sh_S}, {30'd0, vecs[i].exp_s});
            check($sformatf("v%0d_sh_shift", i), {27'd0, sh_shift}, {27'd0, vecs[i].exp_shift});
            check($sformatf("v%0d_sh_B", i), sh_B, vecs[i].exp_b);
            check($sformatf("v%0d_out_valid_early", i), {31'd0, out_valid}, 32'd0);
            tick();
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
`ifdef SHIFT_ISSUE_ERR_EN
            check($sformatf("v%0d_out_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
`endif
            tick();
            check($sformatf("v%0d_out_drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: results 2,4,8,16 from SLL of 1 by 1..4.
        out_ready = 1'b0;
        drive_op(3'b001, 1'b0, 1'b1, 32'd1, 32'd0, 5'd1);
        tick();
        drive_op(3'b001, 1'b0, 1'b1, 32'd1, 32'd0, 5'd2);
        tick();
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_data", out_data, 32'd2);
        check("bp_ready_one_queued", {31'd0, in_ready}, 32'd1);
        drive_op(3'b001, 1'b0, 1'b1, 32'd1, 32'd0, 5'd3);
        tick();
        check("bp_ready_full", {31'd0, in_ready}, 32'd0);
        drive_op(3'b001, 1'b0, 1'b1, 32'd1, 32'd0, 5'd4);
        tick();
        check("bp_ready_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'd2);
        tick();
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_data2", out_data, 32'd2);
        out_ready = 1'b1;
        tick();
        check("bp_drain_2", out_data, 32'd4);
        check("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_drain_3", out_data, 32'd8);
        tick();
        check("bp_drain_4", out_data, 32'd16);
        check("bp_drain_4_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two queued ops and a held result.
        out_ready = 1'b0;
        drive_op(3'b001, 1'b0, 1'b1, 32'd3, 32'd0, 5'd1);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("rst_pre_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_no_stale_%0d", k), {31'd0, out_valid}, 32'd0);
        end
        check("rst_idle_sh_S", {30'd0, sh_S}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_issue_stage.md
# shift_issue_stage

Pipelined front end for the barrel shifter. Accepts raw shift instructions (funct3/funct7 bit, rs1, rs2 or immediate shamt) over a valid/ready handshake and decodes them into the shifter's `S`/`shift`/`B` controls. It buffers them in a 2-entry queue, drives the combinational shifter from the queue head, and registers `H` into a valid/ready result stage. This keeps the shifter out of the critical path and guarantees it never sees the undefined select `S=2'b01`.

## Interface
- `DEPTH`, 2: op-queue entries; only 2 supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `in_valid` in 1: upstream op valid.
- `in_ready` out 1: queue can accept; equals `!full`.
- `in_funct3` in 3: 3'b001 = left shift, 3'b101 = right shift.
- `in_funct7b5` in 1: 1 = arithmetic right.
- `in_imm_sel` in 1: 1 = shamt from `in_shamt_imm`, 0 = from `in_rs2[4:0]`.
- `in_rs1` in 32: operand to shift.
- `in_rs2` in 32: register shamt source.
- `in_shamt_imm` in 5: immediate shamt.
- `sh_S` out 2: to shifter select (00 SLL, 10 SRL, 11 SRA only).
- `sh_shift` out 5: to shifter amount.
- `sh_B` out 32: to shifter operand.
- `sh_H` in 32: shifter result (combinational from `sh_*`).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 32: registered shift result.
- `out_err` out 1: illegal op flag; present only with `SHIFT_ISSUE_ERR_EN`.

## Operation
- Decode at enqueue:
  - funct3=001, b5=0 → SLL.
  - funct3=101, b5=0 → SRL.
  - funct3=101, b5=1 → SRA.
  - Any other combination is illegal.
- Shamt is `in_imm_sel ? in_shamt_imm : in_rs2[4:0]`. Upper rs2 bits are ignored, so no saturation is applied.
- Queue: 2-entry circular buffer with 1-bit read/write pointers and a 2-bit count.
  - Push when `in_valid && in_ready`.
  - Pop when head is valid and the result stage is empty or is being drained (`!out_valid || out_ready`).
  - Simultaneous push and pop while full is not possible, because `in_ready`=0 when full.
  - Simultaneous push and pop at count 1 leaves the count unchanged.
- `sh_*` are driven from the queue head at all times. When the queue is empty, `sh_S`=2'b10, `sh_shift`=0, `sh_B`=0 (SRL by 0, a legal select).
- Result stage: on pop, `out_data` ← `sh_H` and `out_valid` ← 1. It holds while `out_valid && !out_ready`. It clears when drained with no pop.
- Ordering is strict FIFO. No op is dropped or duplicated.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - count=0, pointers=0, `out_valid`=0, `out_data`=0, `out_err`=0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation discards queued ops and the held result. Queue contents are don't-care.
- Latency: op accepted at edge N appears with `out_valid`=1 after edge N+1. Minimum latency is 2 cycles from `in_valid` presentation.
- Throughput: 1 op/cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0, at most 3 ops are in flight (2 queued + 1 result). `in_ready` drops after the 2nd queued op.
- `in_ready` depends only on registered count, never combinationally on `out_ready`.

## Configuration
- `SHIFT_ISSUE_ERR_EN` defined:
  - An illegal op is enqueued with an err bit.
  - On pop it drives `sh_S`=2'b10, `sh_shift`=0, `sh_B`=0.
  - It produces a result with `out_data`=0 and `out_err`=1.
  - `out_err` is valid only with `out_valid`.
- Not defined:
  - An illegal op is accepted and silently decoded as SRL (S=2'b10) with the given operands.
  - There is no err bit in queue storage.
  - The `out_err` port is absent.

## Structure
- `shift_pkg`: `shift_op_e` enum (`OP_SLL`=2'b00, `OP_SRL`=2'b10, `OP_SRA`=2'b11), the funct3 constants, and `shift_req_t` packed struct {op, shamt[4:0], operand[31:0], err under macro}.
- Sub-module `shift_op_fifo` is the 2-entry queue of `shift_req_t` with push/pop/full/empty.
- The shifter is instantiated by the parent, not inside this block.

## Test plan
- Reset, then SLL rs1=32'h0000_0001, rs2=4, imm_sel=0 → `sh_S`=00, `sh_shift`=4; `out_data`=32'h0000_0010 two cycles later with `out_valid`=1.
- SRA rs1=32'h8000_0000, imm=31, imm_sel=1 → `out_data`=32'hFFFF_FFFF. The same op as SRL → 32'h0000_0001.
- Hold `out_ready`=0 and issue 4 back-to-back ops → `in_ready`=0 after the 2nd is queued (3 accepted total). Release `out_ready` → results emerge in order, one per cycle.
- rs2=32'hFFFF_FF23 register SLL of 1 → shamt=3, `out_data`=8 (upper rs2 bits ignored).
- funct3=3'b000 with macro → `out_data`=0, `out_err`=1. Without macro → SRL result, and `sh_S` is never 01 at any cycle.
- Assert `rst_n`=0 with 2 queued ops and a held result → next cycle `out_valid`=0, `in_ready`=1, and no stale result appears afterward.
